nibble_serial_add_ctrl: RTL

Multi-cycle sequencer that adds or subtracts two NIBBLES×4-bit operands using a single instance of the team's 4-bit ripple-carry adder (RCA), one nibble per clock, LSB nibble first.
- Registers the carry between nibbles and collects the result in a shift register.
- Reports result, carry-out and signed overflow with a START/BUSY/DONE handshake.
- Sits between the switch/button front end and the 7-segment display path in the lab datapath.

---
 rtl/nibble_serial_add_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit RCA, one nibble per clock, LSB nibble first.
// Optional running accumulator (ACC port, A taken from S) enabled by defining NIBBLE_ADD_ACC_EN.

module rca4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_c;

    assign w_c[0] = i_ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_co = w_c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_sub,
    input  logic                   i_ci,
    input  logic [4*NIBBLES-1:0]   i_a,
    input  logic [4*NIBBLES-1:0]   i_b,
`ifdef NIBBLE_ADD_ACC_EN
    input  logic                   i_acc,
`endif
    output logic [4*NIBBLES-1:0]   o_s,
    output logic                   o_co,
    output logic                   o_ovf,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int         W    = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_s;
    logic           r_carry;
    logic           r_co;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;
    logic [2:0]     r_cnt;

    logic [3:0]     w_sum;
    logic           w_co;
    logic [W-1:0]   w_a_src;
    logic [W-1:0]   w_a_shift;
    logic [W-1:0]   w_b_shift;
    logic [W-1:0]   w_res_shift;

`ifdef NIBBLE_ADD_ACC_EN
    assign w_a_src = i_acc ? r_s : i_a;
`else
    assign w_a_src = i_a;
`endif

    rca4 u_rca (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0]),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // The partial result only needs the upper W-4 bits; the newest nibble comes straight from the RCA.
    generate
        if (NIBBLES == 1) begin : g_one
            assign w_a_shift   = '0;
            assign w_b_shift   = '0;
            assign w_res_shift = w_sum;
        end else begin : g_multi
            logic [W-5:0] r_res;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_res <= '0;
                end else if (r_state == RUN) begin
                    r_res <= w_res_shift[W-1:4];
                end
            end

            assign w_a_shift   = {4'b0000, r_a[W-1:4]};
            assign w_b_shift   = {4'b0000, r_b[W-1:4]};
            assign w_res_shift = {w_sum, r_res};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= w_a_src;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? 1'b1 : i_ci;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    r_a     <= w_a_shift;
                    r_b     <= w_b_shift;
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == LAST) begin
                        // r_a/r_b now hold the MSB nibble, so bit 3 is each operand's sign.
                        r_s     <= w_res_shift;
                        r_co    <= w_co;
                        r_ovf   <= (r_a[3] == r_b[3]) && (w_sum[3] != r_a[3]);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_s    = r_s;
    assign o_co   = r_co;
    assign o_ovf  = r_ovf;
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule
